// File: rtl/seg_disp_pkg.sv
// Shared types and constants for the multiplexed seven-segment display:
// FSM states, blank/minus patterns and the decimal glyph table.
package seg_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_COMMIT  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_MINUS = 7'h40;

  // Index d holds the {g,f,e,d,c,b,a} glyph for decimal digit d
  localparam logic [9:0][6:0] SEG_DIGIT = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [3:0] add3_nibble(input logic [3:0] i_nib);
    if (i_nib >= 4'd5) begin
      return i_nib + 4'd3;
    end else begin
      return i_nib;
    end
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD digit to seven-segment glyph decoder; non-decimal codes
// decode to a blank digit.
module bcd_to_seg
  import seg_disp_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (i_bcd <= 4'd9) begin
      o_seg = SEG_DIGIT[i_bcd];
    end else begin
      o_seg = SEG_BLANK;
    end
  end

endmodule

// File: rtl/seg_scan_display.sv
// Signed decimal display driver: sequential double-dabble conversion of a
// captured magnitude, atomic pattern commit, and a free-running digit scan.
module seg_scan_display
  import seg_disp_pkg::*;
#(
  parameter int DATA_W   = 10,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1024
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_neg,
  input  logic              i_error,
  input  logic              i_load,
  output logic              o_busy,
  output logic              o_overflow,
  output logic [6:0]        o_seg,
  output logic [DIGITS-1:0] o_digit_en
);

  // The BCD register holds every digit DATA_W bits can produce, so values
  // wider than the display are still seen whole by the overflow check.
  localparam int CONV_DIGITS = (DATA_W * 301) / 1000 + 1;
  localparam int BCD_DIGITS  = (CONV_DIGITS > DIGITS) ? CONV_DIGITS : DIGITS;
  localparam int BCD_W       = 4 * BCD_DIGITS;
  localparam int CNT_W       = $clog2(DATA_W);
  localparam int PRE_W       = $clog2(SCAN_DIV);
  localparam int IDX_W       = $clog2(DIGITS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  state_t                  r_state;
  state_t                  w_state_next;
  logic [DATA_W-1:0]       r_bin;
  logic [BCD_W-1:0]        r_bcd;
  logic [BCD_W-1:0]        w_bcd_adj;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_neg;
  logic                    r_err;
  logic                    r_busy;
  logic                    r_ovf;
  logic                    w_ovf;
  logic [BCD_DIGITS-1:0]   w_nz_above;
  logic [DIGITS-1:0][6:0]  w_dig_seg;
  logic [DIGITS-1:0][6:0]  w_pat_new;
  logic [DIGITS-1:0][6:0]  r_pat;
  logic [PRE_W-1:0]        r_presc;
  logic [IDX_W-1:0]        r_idx;
  logic [IDX_W-1:0]        w_idx_next;
  logic                    w_wrap;
  logic [6:0]              w_seg_next;
  logic [6:0]              r_seg;
  logic [DIGITS-1:0]       r_digit_en;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dec
      bcd_to_seg u_dec (
        .i_bcd (r_bcd[4*g +: 4]),
        .o_seg (w_dig_seg[g])
      );
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_load) begin
          w_state_next = ST_CONVERT;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_CONVERT: begin
        if (r_cnt == CNT_LAST) begin
          w_state_next = ST_COMMIT;
        end else begin
          w_state_next = ST_CONVERT;
        end
      end
      ST_COMMIT: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int k = 0; k < BCD_DIGITS; k++) begin
      w_bcd_adj[4*k +: 4] = add3_nibble(r_bcd[4*k +: 4]);
    end
  end

  // Capture, shift-and-add conversion, and the atomic pattern/overflow commit
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_neg  <= 1'b0;
      r_err  <= 1'b0;
      r_busy <= 1'b0;
      r_ovf  <= 1'b0;
      r_pat  <= {DIGITS{SEG_BLANK}};
    end else begin
      r_busy <= (w_state_next != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (i_load) begin
            r_bin <= i_data;
            r_neg <= i_neg;
            r_err <= i_error;
            r_bcd <= '0;
            r_cnt <= '0;
          end
        end
        ST_CONVERT: begin
          r_bcd <= {w_bcd_adj[BCD_W-2:0], r_bin[DATA_W-1]};
          r_bin <= {r_bin[DATA_W-2:0], 1'b0};
          r_cnt <= r_cnt + CNT_W'(1);
        end
        ST_COMMIT: begin
          r_pat <= w_pat_new;
          r_ovf <= w_ovf;
        end
        default: begin
          r_bcd <= '0;
        end
      endcase
    end
  end

  // Overflow, leading-zero blanking and sign placement from the final BCD value
  always_comb begin
    logic w_acc;
    int   w_cap;
    w_acc      = 1'b0;
    w_cap      = r_neg ? (DIGITS - 1) : DIGITS;
    w_ovf      = 1'b0;
    w_nz_above = '0;
    w_pat_new  = {DIGITS{SEG_BLANK}};
    for (int k = BCD_DIGITS - 1; k >= 0; k--) begin
      w_acc         = w_acc | (r_bcd[4*k +: 4] != 4'd0);
      w_nz_above[k] = w_acc;
      w_ovf         = w_ovf | ((k >= w_cap) && (r_bcd[4*k +: 4] != 4'd0));
    end
    for (int k = 0; k < DIGITS; k++) begin
      if (r_err || w_ovf) begin
        w_pat_new[k] = SEG_MINUS;
      end else if (r_neg && (k == DIGITS - 1)) begin
        w_pat_new[k] = SEG_MINUS;
      end else if ((k == 0) || w_nz_above[k]) begin
        w_pat_new[k] = w_dig_seg[k];
      end else begin
        w_pat_new[k] = SEG_BLANK;
      end
    end
  end

  // During COMMIT the fresh patterns bypass r_pat so seg updates with them
  always_comb begin
    w_wrap = (r_presc == PRE_LAST);
    if (w_wrap) begin
      if (r_idx == IDX_LAST) begin
        w_idx_next = '0;
      end else begin
        w_idx_next = r_idx + IDX_W'(1);
      end
    end else begin
      w_idx_next = r_idx;
    end
    if (r_state == ST_COMMIT) begin
      w_seg_next = w_pat_new[w_idx_next];
    end else begin
      w_seg_next = r_pat[w_idx_next];
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_presc    <= '0;
      r_idx      <= '0;
      r_seg      <= SEG_BLANK;
      r_digit_en <= DIGITS'(1);
    end else begin
      if (w_wrap) begin
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + PRE_W'(1);
      end
      r_idx      <= w_idx_next;
      r_seg      <= w_seg_next;
      r_digit_en <= DIGITS'(1) << w_idx_next;
    end
  end

  assign o_busy     = r_busy;
  assign o_overflow = r_ovf;
  assign o_seg      = r_seg;
  assign o_digit_en = r_digit_en;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with a decimal-arithmetic reference
// model compared against the outputs on every falling clock edge.
module tb_seg_scan_display;

  localparam int DATA_W   = 10;
  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int BUSY_LEN = DATA_W + 1;
  localparam logic [6:0] TB_PAT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                         7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] data;
  logic              neg;
  logic              err;
  logic              load;
  logic              busy;
  logic              ovf;
  logic [6:0]        seg;
  logic [DIGITS-1:0] digit_en;

  int   n_checks = 0;
  int   n_pass   = 0;
  logic chk_en   = 1'b0;

  int         m_n;
  int         m_cnt;
  int         m_val;
  bit         m_neg;
  bit         m_err;
  bit         m_ovf;
  logic [6:0] m_pat [DIGITS];
  logic [6:0] rd [DIGITS];
  int         bcyc;

  seg_scan_display #(
    .DATA_W   (DATA_W),
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_data     (data),
    .i_neg      (neg),
    .i_error    (err),
    .i_load     (load),
    .o_busy     (busy),
    .o_overflow (ovf),
    .o_seg      (seg),
    .o_digit_en (digit_en)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pow10(input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  function automatic bit model_ovf(input int v, input bit n);
    return v >= pow10(n ? DIGITS - 1 : DIGITS);
  endfunction

  function automatic logic [6:0] model_digit(input int v, input bit n, input bit e, input int k);
    if (e || model_ovf(v, n)) return 7'h40;
    if (n && (k == DIGITS - 1)) return 7'h40;
    if ((k == 0) || (v >= pow10(k))) return TB_PAT[(v / pow10(k)) % 10];
    return 7'h00;
  endfunction

  // Reference: count edges for the scan, count down the busy window, commit at its end
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_n   <= 0;
      m_cnt <= 0;
      m_ovf <= 1'b0;
      for (int k = 0; k < DIGITS; k++) m_pat[k] <= 7'h00;
    end else begin
      m_n <= m_n + 1;
      if (m_cnt == 0) begin
        if (load) begin
          m_val <= int'(data);
          m_neg <= neg;
          m_err <= err;
          m_cnt <= BUSY_LEN;
        end
      end else begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_ovf <= model_ovf(m_val, m_neg);
          for (int k = 0; k < DIGITS; k++) m_pat[k] <= model_digit(m_val, m_neg, m_err, k);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int idx;
      idx = (m_n / SCAN_DIV) % DIGITS;
      check("cyc_busy", 32'(busy), 32'(m_cnt != 0));
      check("cyc_ovf", 32'(ovf), 32'(m_ovf));
      check("cyc_digit_en", 32'(digit_en), 32'(1) << idx);
      check("cyc_seg", 32'(seg), 32'(m_pat[idx]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int v, input bit n, input bit e, output int cycles);
    data  = DATA_W'(v);
    neg   = n;
    err   = e;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    cycles = 0;
    while (busy && (cycles < 40)) begin
      cycles++;
      tick();
    end
    check("busy_done", 32'(busy), 32'(0));
  endtask

  task automatic read_digits();
    for (int k = 0; k < DIGITS; k++) rd[k] = 7'h55;
    for (int c = 0; c < SCAN_DIV * DIGITS; c++) begin
      tick();
      for (int k = 0; k < DIGITS; k++) begin
        if (digit_en[k]) rd[k] = seg;
      end
    end
  endtask

  task automatic check_digits(input string name, input logic [6:0] d3, input logic [6:0] d2,
                              input logic [6:0] d1, input logic [6:0] d0);
    read_digits();
    check({name, "_d3"}, 32'(rd[3]), 32'(d3));
    check({name, "_d2"}, 32'(rd[2]), 32'(d2));
    check({name, "_d1"}, 32'(rd[1]), 32'(d1));
    check({name, "_d0"}, 32'(rd[0]), 32'(d0));
  endtask

  initial begin
    rst  = 1'b0;
    data = '0;
    neg  = 1'b0;
    err  = 1'b0;
    load = 1'b0;
    #2;
    rst    = 1'b1;
    chk_en = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_ovf", 32'(ovf), 32'(0));
    check("rst_digit_en", 32'(digit_en), 32'h1);
    check("rst_seg", 32'(seg), 32'h00);
    repeat (4) tick();
    check("scan_1", 32'(digit_en), 32'h2);
    repeat (4) tick();
    check("scan_2", 32'(digit_en), 32'h4);
    repeat (4) tick();
    check("scan_3", 32'(digit_en), 32'h8);
    repeat (4) tick();
    check("scan_wrap", 32'(digit_en), 32'h1);

    do_load(1023, 1'b0, 1'b0, bcyc);
    check("fs_busy_len", 32'(bcyc), 32'd11);
    check("fs_model_d3", 32'(m_pat[3]), 32'h06);
    check("fs_model_d0", 32'(m_pat[0]), 32'h4F);
    check("fs_ovf", 32'(ovf), 32'(0));
    check_digits("fs", 7'h06, 7'h3F, 7'h5B, 7'h4F);

    do_load(7, 1'b1, 1'b0, bcyc);
    check_digits("neg7", 7'h40, 7'h00, 7'h00, 7'h07);

    do_load(560, 1'b0, 1'b0, bcyc);
    check_digits("p560", 7'h00, 7'h6D, 7'h7D, 7'h3F);

    do_load(999, 1'b1, 1'b0, bcyc);
    check("n999_ovf", 32'(ovf), 32'(0));
    check_digits("n999", 7'h40, 7'h6F, 7'h6F, 7'h6F);

    do_load(1000, 1'b1, 1'b0, bcyc);
    check("ovf_set", 32'(ovf), 32'(1));
    check_digits("ovf", 7'h40, 7'h40, 7'h40, 7'h40);

    do_load(0, 1'b0, 1'b0, bcyc);
    check("ovf_clr", 32'(ovf), 32'(0));
    check_digits("zero", 7'h00, 7'h00, 7'h00, 7'h3F);

    do_load(5, 1'b0, 1'b1, bcyc);
    check("err_ovf", 32'(ovf), 32'(0));
    check_digits("err", 7'h40, 7'h40, 7'h40, 7'h40);

    // Second load lands in busy cycle 3 and must be dropped
    data = 10'd42;
    neg  = 1'b0;
    err  = 1'b0;
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tick();
    data = 10'd999;
    load = 1'b1;
    tick();
    load = 1'b0;
    bcyc = 0;
    while (busy && (bcyc < 40)) begin
      bcyc++;
      tick();
    end
    check("ign_busy_done", 32'(busy), 32'(0));
    check_digits("ign", 7'h00, 7'h00, 7'h66, 7'h5B);

    // Reset in busy cycle 5 abandons the conversion
    data = 10'd555;
    load = 1'b1;
    tick();
    load = 1'b0;
    repeat (4) tick();
    check("mid_busy", 32'(busy), 32'(1));
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'(0));
    check("mid_rst_ovf", 32'(ovf), 32'(0));
    check_digits("mid_rst", 7'h00, 7'h00, 7'h00, 7'h00);
    repeat (12) tick();
    check("mid_rst_idle", 32'(busy), 32'(0));

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
